memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles mem_req is held high without mem_ready before the access is aborted (legal range 1-255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port enabled, input, 1, a one-cycle start pulse from the execute stage.
REQ-005 The block SHALL have ports is_load / is_store, input, 1 each, instruction class (both 0 = non-memory instruction).
REQ-006 The block SHALL have port funct3, input, 3, access size and sign (RV32I load/store encoding).
REQ-007 The block SHALL have ports alu_result (effective address or ALU result) and rs2_data (store data), input, 32 each.
REQ-008 The block SHALL have ports mem_req, mem_we, output, 1 each; mem_addr, mem_wdata, output, 32 each; mem_wstrb, output, 4.
REQ-009 The block SHALL have ports mem_ready, input, 1, and mem_rdata, input, 32.
REQ-010 The block SHALL have ports reg_data, output, 32, the value handed to write-back; error, output, 1, misaligned access or timeout; completed, output, 1, completion pulse.

Function
REQ-011 The FSM SHALL have states IDLE, REQ and DONE.
REQ-012 enabled SHALL be sampled only in IDLE and ignored in REQ and DONE.
REQ-013 Non-memory instruction: IDLE->DONE; reg_data = alu_result; error = 0; no mem_req.
REQ-014 Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0): IDLE->DONE; error = 1; reg_data = 0; no mem_req.
REQ-015 Aligned load or store: IDLE->REQ; mem_req SHALL go high on the following cycle and stay high until mem_ready is sampled high or the timeout fires.
REQ-016 In REQ, mem_addr SHALL be {alu_result[31:2],2'b00} and mem_we SHALL equal is_store; mem_addr, mem_we, mem_wdata and mem_wstrb SHALL be registered at start and held stable throughout REQ.
REQ-017 Store lanes: SB: wdata = rs2[7:0] replicated to 4 bytes, wstrb = 0001 << addr[1:0]. SH: wdata = rs2[15:0] replicated to 2 halves, wstrb = 0011 << addr[1:0]. SW: wdata = rs2, wstrb = 1111.
REQ-018 Load extraction: select the byte or half at addr[1:0] of mem_rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word. Unused funct3 codes SHALL be treated as LW.
REQ-019 On a cycle with mem_req=1 and mem_ready=1: the handshake completes, mem_req SHALL drop on the next edge, and the state SHALL go REQ->DONE.
REQ-020 On that completing cycle, a load SHALL latch the extracted mem_rdata into reg_data; a store SHALL set reg_data to 0.
REQ-021 Timeout: if mem_ready is not seen within TIMEOUT cycles of mem_req high, the block SHALL drop mem_req and go REQ->DONE with error = 1 and reg_data = 0.
REQ-022 A timeout counter SHALL count cycles in REQ and clear on entry to REQ.
REQ-023 If mem_ready arrives on the same cycle the count reaches TIMEOUT, the handshake SHALL win and error SHALL be 0.
REQ-024 DONE SHALL last exactly one cycle with completed = 1, then return to IDLE.
REQ-025 reg_data and error SHALL hold their values until the next DONE.
REQ-026 Minimum latency from enabled to completed SHALL be 1 cycle for non-memory/misaligned and 2 cycles for a memory access with mem_ready already high.
REQ-027 mem_req, mem_we and mem_wstrb SHALL be 0 in every state except REQ.

Reset
REQ-028 With rst=1 at a clock edge, the state SHALL go to IDLE and all outputs SHALL be 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, reg_data, error, completed), the timeout counter SHALL clear, and no completed pulse SHALL be emitted.
REQ-029 Reset asserted during REQ SHALL drop mem_req at that edge and abandon the access.

Verification
REQ-030 The bench SHALL cover this scenario: LB at addr 0x103, mem_rdata=0x80FF_1234, mem_ready high immediately -> mem_addr=0x100, completed 2 cycles after enabled, reg_data=0xFFFF_FF80.
REQ-031 The bench SHALL cover this scenario: SH at addr 0x202, rs2=0x1234_ABCD -> mem_we=1, mem_wdata=0xABCD_ABCD, mem_wstrb=1100, reg_data=0.
REQ-032 The bench SHALL cover this scenario: LW at addr 0x006 -> no mem_req, completed 1 cycle after enabled, error=1, reg_data=0.
REQ-033 The bench SHALL cover this scenario: LHU at 0x10, mem_ready delayed 5 cycles, TIMEOUT=16 -> mem_req high 6 cycles with stable address, error=0, reg_data zero-extended.
REQ-034 The bench SHALL cover this scenario: LW with mem_ready never asserted, TIMEOUT=4 -> mem_req drops after 4 cycles, error=1, single completed pulse; a second enabled during REQ is ignored.
REQ-035 The bench SHALL cover this scenario: rst asserted mid-REQ -> mem_req=0 at next edge, no completed, next enabled with a non-memory op gives reg_data=alu_result.

Source files
------------

// File: rtl/memory_access_if.sv
// Data-memory request/response bus between the memory-access stage and the memory.
interface memory_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// RV32I memory-access stage: issues one load/store per start pulse over a
// req/ready bus, with alignment checking and a request timeout.
module memory_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enabled,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic [2:0]             funct3,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            rs2_data,
  memory_access_if.master        mem,
  output logic [31:0]            reg_data,
  output logic                   error,
  output logic                   completed
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        is_store_q;

  logic        size_byte, size_half, misaligned;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Unused funct3 codes decode as word-sized accesses.
  always_comb begin
    size_byte  = (funct3 == 3'b000) || (funct3 == 3'b100);
    size_half  = (funct3 == 3'b001) || (funct3 == 3'b101);
    misaligned = 1'b0;
    if (size_half)       misaligned = alu_result[0];
    else if (!size_byte) misaligned = (alu_result[1:0] != 2'b00);
  end

  always_comb begin
    wdata_c = rs2_data;
    wstrb_c = 4'b1111;
    if (size_byte) begin
      wdata_c = {4{rs2_data[7:0]}};
      wstrb_c = 4'b0001 << alu_result[1:0];
    end else if (size_half) begin
      wdata_c = {2{rs2_data[15:0]}};
      wstrb_c = 4'b0011 << alu_result[1:0];
    end
  end

  always_comb begin
    shifted = mem.mem_rdata >> {off_q, 3'b000};
    unique case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      is_store_q    <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
      reg_data      <= '0;
      error         <= 1'b0;
      completed     <= 1'b0;
    end else begin
      completed <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enabled) begin
            if (!is_load && !is_store) begin
              reg_data  <= alu_result;
              error     <= 1'b0;
              completed <= 1'b1;
              state_q   <= StDone;
            end else if (misaligned) begin
              reg_data  <= '0;
              error     <= 1'b1;
              completed <= 1'b1;
              state_q   <= StDone;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_store;
              mem.mem_addr  <= {alu_result[31:2], 2'b00};
              mem.mem_wdata <= wdata_c;
              mem.mem_wstrb <= is_store ? wstrb_c : 4'b0000;
              cnt_q         <= '0;
              funct3_q      <= funct3;
              off_q         <= alu_result[1:0];
              is_store_q    <= is_store;
              state_q       <= StReq;
            end
          end
        end
        StReq: begin
          // A ready on the final allowed cycle still beats the timeout.
          if (mem.mem_ready || (cnt_q == 8'(TIMEOUT - 1))) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wstrb <= 4'b0000;
            completed     <= 1'b1;
            state_q       <= StDone;
            if (mem.mem_ready) begin
              reg_data <= is_store_q ? 32'h0 : load_data;
              error    <= 1'b0;
            end else begin
              reg_data <= '0;
              error    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: one TIMEOUT=16 instance and one TIMEOUT=4 instance.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic [31:0] reg_data16, reg_data4;
  logic        error16, error4;
  logic        completed16, completed4;

  int n_tests = 0;
  int n_fail  = 0;

  memory_access_if if16 ();
  memory_access_if if4 ();

  memory_access #(.TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst), .enabled(enabled), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .alu_result(alu_result), .rs2_data(rs2_data), .mem(if16.master),
    .reg_data(reg_data16), .error(error16), .completed(completed16)
  );

  memory_access #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .enabled(enabled), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .alu_result(alu_result), .rs2_data(rs2_data), .mem(if4.master),
    .reg_data(reg_data4), .error(error4), .completed(completed4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enabled = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one instruction for a single cycle; returns #1 after the sampling edge.
  task automatic start_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2);
    is_load = ld; is_store = st; funct3 = f3; alu_result = addr; rs2_data = rs2;
    enabled = 1'b1;
    tick();
    enabled = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enabled = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({if16.mem_req, if16.mem_we, if16.mem_wstrb, completed16, error16} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {if16.mem_req, if16.mem_we, if16.mem_wstrb, completed16, error16});
    end
    n_tests++;
    if ({if16.mem_addr, if16.mem_wdata, reg_data16} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h reg %h want all 0",
               if16.mem_addr, if16.mem_wdata, reg_data16);
    end
    rst = 1'b0;
  endtask

  task automatic test_lb_signed();
    do_reset();
    if16.mem_ready = 1'b1; if16.mem_rdata = 32'h80FF_1234;
    start_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    n_tests++;
    if (if16.mem_req !== 1'b1 || if16.mem_addr !== 32'h100 || if16.mem_we !== 1'b0
        || completed16 !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_req: req %b addr %h we %b done %b want 1 00000100 0 0",
               if16.mem_req, if16.mem_addr, if16.mem_we, completed16);
    end
    tick();
    n_tests++;
    if (completed16 !== 1'b1 || reg_data16 !== 32'hFFFF_FF80 || error16 !== 1'b0
        || if16.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_done: done %b reg %h err %b req %b want 1 ffffff80 0 0",
               completed16, reg_data16, error16, if16.mem_req);
    end
    tick();
    n_tests++;
    if (completed16 !== 1'b0 || reg_data16 !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_hold: done %b reg %h want 0 ffffff80", completed16, reg_data16);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [4] = '{3'b001, 3'b100, 3'b010, 3'b011};
    logic [31:0] adr [4] = '{32'h402, 32'h402, 32'h400, 32'h404};
    logic [31:0] exp [4] = '{32'hFFFF_80FF, 32'h0000_00FF, 32'h80FF_1234, 32'h80FF_1234};
    do_reset();
    if16.mem_ready = 1'b1; if16.mem_rdata = 32'h80FF_1234;
    for (int i = 0; i < 4; i++) begin
      start_op(1'b1, 1'b0, f3[i], adr[i], 32'h0);
      tick();
      n_tests++;
      if (completed16 !== 1'b1 || reg_data16 !== exp[i]) begin
        n_fail++;
        $display("FAIL load_%0d: done %b reg %h want 1 %h", i, completed16, reg_data16, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_store_half();
    do_reset();
    if16.mem_ready = 1'b1;
    start_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    n_tests++;
    if (if16.mem_req !== 1'b1 || if16.mem_we !== 1'b1 || if16.mem_addr !== 32'h200
        || if16.mem_wdata !== 32'hABCD_ABCD || if16.mem_wstrb !== 4'b1100) begin
      n_fail++;
      $display("FAIL sh_req: req %b we %b addr %h wdata %h wstrb %b want 1 1 200 abcdabcd 1100",
               if16.mem_req, if16.mem_we, if16.mem_addr, if16.mem_wdata, if16.mem_wstrb);
    end
    tick();
    n_tests++;
    if (completed16 !== 1'b1 || reg_data16 !== 32'h0 || if16.mem_we !== 1'b0
        || if16.mem_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL sh_done: done %b reg %h we %b wstrb %b want 1 0 0 0000",
               completed16, reg_data16, if16.mem_we, if16.mem_wstrb);
    end
    tick();
  endtask

  task automatic test_store_byte_word();
    do_reset();
    if16.mem_ready = 1'b1;
    start_op(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'hAABB_CC77);
    n_tests++;
    if (if16.mem_wdata !== 32'h7777_7777 || if16.mem_wstrb !== 4'b0010) begin
      n_fail++;
      $display("FAIL sb_lanes: wdata %h wstrb %b want 77777777 0010",
               if16.mem_wdata, if16.mem_wstrb);
    end
    tick();
    tick();
    start_op(1'b0, 1'b1, 3'b010, 32'h0000_0308, 32'hDEAD_BEEF);
    n_tests++;
    if (if16.mem_wdata !== 32'hDEAD_BEEF || if16.mem_wstrb !== 4'b1111
        || if16.mem_addr !== 32'h308) begin
      n_fail++;
      $display("FAIL sw_lanes: wdata %h wstrb %b addr %h want deadbeef 1111 308",
               if16.mem_wdata, if16.mem_wstrb, if16.mem_addr);
    end
    tick();
    tick();
  endtask

  task automatic test_misaligned();
    do_reset();
    if16.mem_ready = 1'b1;
    start_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    n_tests++;
    if (completed16 !== 1'b1 || error16 !== 1'b1 || reg_data16 !== 32'h0
        || if16.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned: done %b err %b reg %h req %b want 1 1 0 0",
               completed16, error16, reg_data16, if16.mem_req);
    end
    tick();
    n_tests++;
    if (completed16 !== 1'b0 || error16 !== 1'b1 || if16.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_hold: done %b err %b req %b want 0 1 0",
               completed16, error16, if16.mem_req);
    end
  endtask

  task automatic test_delayed_ready();
    int high = 0;
    do_reset();
    if16.mem_ready = 1'b0; if16.mem_rdata = 32'h1234_F00D;
    start_op(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) if16.mem_ready = 1'b1;
      if (if16.mem_req === 1'b1 && if16.mem_addr === 32'h10) high++;
      tick();
    end
    if16.mem_ready = 1'b0;
    n_tests++;
    if (high != 6) begin
      n_fail++;
      $display("FAIL lhu_req_cycles: got %0d want 6", high);
    end
    n_tests++;
    if (completed16 !== 1'b1 || error16 !== 1'b0 || reg_data16 !== 32'h0000_F00D
        || if16.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu_done: done %b err %b reg %h req %b want 1 0 0000f00d 0",
               completed16, error16, reg_data16, if16.mem_req);
    end
    tick();
  endtask

  task automatic test_timeout();
    int high = 0;
    int dones = 0;
    do_reset();
    if4.mem_ready = 1'b0;
    start_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (if4.mem_req === 1'b1) high++;
      if (completed4 === 1'b1) dones++;
      // A non-memory start while in REQ must not be taken.
      if (i == 1) begin
        is_load = 1'b0; is_store = 1'b0; alu_result = 32'h0000_BEEF; enabled = 1'b1;
      end else begin
        enabled = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (high != 4) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: got %0d want 4", high);
    end
    n_tests++;
    if (dones != 1 || error4 !== 1'b1 || reg_data4 !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_done: pulses %0d err %b reg %h want 1 1 0", dones, error4, reg_data4);
    end
  endtask

  task automatic test_ready_at_timeout();
    do_reset();
    if4.mem_ready = 1'b0; if4.mem_rdata = 32'hCAFE_BABE;
    start_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    tick();
    tick();
    tick();
    if4.mem_ready = 1'b1;
    tick();
    if4.mem_ready = 1'b0;
    n_tests++;
    if (completed4 !== 1'b1 || error4 !== 1'b0 || reg_data4 !== 32'hCAFE_BABE) begin
      n_fail++;
      $display("FAIL ready_at_limit: done %b err %b reg %h want 1 0 cafebabe",
               completed4, error4, reg_data4);
    end
    tick();
  endtask

  task automatic test_reset_mid_req();
    int dones = 0;
    do_reset();
    if16.mem_ready = 1'b0;
    start_op(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (if16.mem_req !== 1'b0 || completed16 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_req: req %b done %b want 0 0", if16.mem_req, completed16);
    end
    for (int i = 0; i < 20; i++) begin
      if (completed16 === 1'b1 || if16.mem_req === 1'b1) dones++;
      tick();
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rst_abandon: got %0d active cycles want 0", dones);
    end
    start_op(1'b0, 1'b0, 3'b000, 32'h5555_AAAA, 32'h0);
    n_tests++;
    if (completed16 !== 1'b1 || reg_data16 !== 32'h5555_AAAA || error16 !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem_after_rst: done %b reg %h err %b want 1 5555aaaa 0",
               completed16, reg_data16, error16);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; enabled = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; alu_result = '0; rs2_data = '0;
    if16.mem_ready = 1'b0; if16.mem_rdata = '0;
    if4.mem_ready = 1'b0; if4.mem_rdata = '0;
    test_reset();
    test_lb_signed();
    test_loads();
    test_store_half();
    test_store_byte_word();
    test_misaligned();
    test_delayed_ready();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
